// File: rtl/lfsr_noise_pkg.sv
// Shared types and widths for the LFSR noise arbiter and the LFSR it drives.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_noise_pkg;

    // Widths of the shared LFSR noise generator's data input and sample output.
    localparam int DATA_W   = 12;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr_noise_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (request vector), last (previous winner) -> winner (picked ID), any (some request set).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] rot;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        rot    = '0;
        // Scan last+1, last+2, ... with wrap; the first hit is the nearest
        // requester after the previous winner, so it takes priority.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            rot = req >> idx;
            if (!any && rot[0]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lfsr_noise_arbiter.sv
// Shares one LFSR noise generator among NUM_REQ requesters, round-robin, one sample per grant.
// Latency: request sampled at t -> gnt at t+1 -> enable t+1..t+steps -> rsp_valid at t+steps+2.
// Backpressure: none on responses; requesters hold req until gnt, arb_en=0 blocks new grants only.
// Ports: clk/reset (sync, active-high); arb_en, steps, req, req_data in; gnt out;
//        lfsr_enable/lfsr_data to the LFSR, lfsr_out16 from it; rsp_valid/rsp_id/rsp_sample out; busy out.
module lfsr_noise_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int STEP_W   = 5,
    parameter int DATA_W   = lfsr_noise_pkg::DATA_W,
    parameter int SAMPLE_W = lfsr_noise_pkg::SAMPLE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_en,
    input  logic [STEP_W-1:0]         steps,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      lfsr_enable,
    output logic [DATA_W-1:0]         lfsr_data,
    input  logic [SAMPLE_W-1:0]       lfsr_out16,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [SAMPLE_W-1:0]       rsp_sample,
    output logic                      busy
);

    import lfsr_noise_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   cnt;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     win;
    logic                any;
    logic [DATA_W-1:0]   sel_data;
    logic                grant_go;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .last   (last),
        .winner (win),
        .any    (any)
    );

    // Data word of the current winner; only used on the grant edge.
    assign sel_data = DATA_W'(req_data >> (int'(win) * DATA_W));
    assign grant_go = (state == IDLE) && arb_en && any;

    // The LFSR only steps while RUN; its data input holds the granted word otherwise.
    assign lfsr_enable = (state == RUN);
    assign lfsr_data   = data_q;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go) state_nxt = RUN;
            RUN:     if (cnt == STEP_W'(1)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant bookkeeping, step counter, sample capture. Reset abandons any
    // transaction in flight, so a pending capture never turns into a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            data_q     <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sample <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_go) begin
                        id_q   <= win;
                        data_q <= sel_data;
                        // A step count of zero still advances the LFSR once.
                        cnt    <= (steps == '0) ? STEP_W'(1) : steps;
                        last   <= win;
                        gnt    <= NUM_REQ'(1) << win;
                    end
                end
                RUN: begin
                    cnt <= cnt - STEP_W'(1);
                end
                CAPTURE: begin
                    rsp_sample <= lfsr_out16;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_noise_arbiter.sv
// Self-checking bench for lfsr_noise_arbiter: vector table, directed corner sequences, random phase.
// A transaction-level schedule model checks every output on every cycle.
module tb_lfsr_noise_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int STEP_W   = 5;
    localparam int DATA_W   = 12;
    localparam int SAMPLE_W = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      arb_en;
    logic [STEP_W-1:0]         steps;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      lfsr_enable;
    logic [DATA_W-1:0]         lfsr_data;
    logic [SAMPLE_W-1:0]       lfsr_out16;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [SAMPLE_W-1:0]       rsp_sample;
    logic                      busy;

    always #5 clk = ~clk;

    lfsr_noise_arbiter #(
        .NUM_REQ (NUM_REQ), .ID_W (ID_W), .STEP_W (STEP_W), .DATA_W (DATA_W), .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk (clk), .reset (reset), .arb_en (arb_en), .steps (steps), .req (req),
        .req_data (req_data), .gnt (gnt), .lfsr_enable (lfsr_enable), .lfsr_data (lfsr_data),
        .lfsr_out16 (lfsr_out16), .rsp_valid (rsp_valid), .rsp_id (rsp_id),
        .rsp_sample (rsp_sample), .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- observed outputs of the most recent cycle ----------------
    logic [NUM_REQ-1:0]  obs_gnt;
    logic                obs_en, obs_rv, obs_busy;
    logic [DATA_W-1:0]   obs_data;
    logic [ID_W-1:0]     obs_id;
    logic [SAMPLE_W-1:0] obs_sample;

    // ---------------- reference model: transaction schedule ----------------
    // A grant decided at the end of cycle c with n=max(steps,1) owns cycles c+1..c+n+1;
    // the response appears at c+n+2, which is also the next cycle a grant may be decided.
    int                  cyc = 0;
    bit                  m_ok = 0;
    int                  m_idle_at, m_gnt_cyc, m_run_start, m_run_end, m_cap_cyc, m_rsp_cyc;
    int                  m_last, m_id;
    logic [DATA_W-1:0]   m_data;
    logic [ID_W-1:0]     m_rsp_id;
    logic [SAMPLE_W-1:0] m_rsp_sample;

    function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int lst);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (lst + k) % NUM_REQ;
            if (((r >> c) & NUM_REQ'(1)) != '0) return c;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (((v >> i) & NUM_REQ'(1)) != '0) return i;
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] slot(input int i);
        return DATA_W'(req_data >> (i * DATA_W));
    endfunction

    task automatic model_check();
        logic [NUM_REQ-1:0] eg;
        bit                 in_run, in_busy;
        eg      = (cyc == m_gnt_cyc) ? (NUM_REQ'(1) << m_id) : '0;
        in_run  = (cyc >= m_run_start) && (cyc <= m_run_end);
        in_busy = (cyc >= m_run_start) && (cyc <= m_cap_cyc);
        chk("model_gnt",         32'(obs_gnt),    32'(eg));
        chk("model_lfsr_enable", 32'(obs_en),     32'(in_run));
        chk("model_lfsr_data",   32'(obs_data),   32'(m_data));
        chk("model_busy",        32'(obs_busy),   32'(in_busy));
        chk("model_rsp_valid",   32'(obs_rv),     32'(cyc == m_rsp_cyc));
        chk("model_rsp_id",      32'(obs_id),     32'(m_rsp_id));
        chk("model_rsp_sample",  32'(obs_sample), 32'(m_rsp_sample));
    endtask

    task automatic model_update();
        if (reset) begin
            m_ok = 1;
            m_idle_at = cyc + 1;
            m_gnt_cyc = -10; m_run_start = -10; m_run_end = -10; m_cap_cyc = -10; m_rsp_cyc = -10;
            m_last = NUM_REQ - 1; m_id = 0;
            m_data = '0; m_rsp_id = '0; m_rsp_sample = '0;
        end else if (m_ok) begin
            if (cyc == m_cap_cyc) begin
                m_rsp_id     = ID_W'(m_id);
                m_rsp_sample = lfsr_out16;
            end
            if (cyc >= m_idle_at && arb_en && req != '0) begin
                int n;
                n           = (steps == '0) ? 1 : int'(steps);
                m_id        = rr_model(req, m_last);
                m_last      = m_id;
                m_data      = slot(m_id);
                m_gnt_cyc   = cyc + 1;
                m_run_start = cyc + 1;
                m_run_end   = cyc + n;
                m_cap_cyc   = cyc + n + 1;
                m_rsp_cyc   = cyc + n + 2;
                m_idle_at   = cyc + n + 2;
            end
        end
    endtask

    // One clock: observe at the falling edge, let the model see this cycle's inputs,
    // then return just after the rising edge so callers can drive the next cycle.
    task automatic tick();
        @(negedge clk);
        obs_gnt = gnt; obs_en = lfsr_enable; obs_data = lfsr_data; obs_rv = rsp_valid;
        obs_id = rsp_id; obs_sample = rsp_sample; obs_busy = busy;
        if (m_ok) model_check();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        int   gid;   // granted ID (-1 if none)
        int   gk;    // cycle offset of gnt
        int   en;    // enable cycles seen
        int   rk;    // cycle offset of rsp_valid (-1 if none)
        bit   data_ok;
        int   id;
        logic [SAMPLE_W-1:0] sample;
    } txn_t;

    // Single transaction from idle: request is held until gnt, then dropped.
    // chg_steps >= 0 rewrites steps right after the grant.
    task automatic do_txn(input logic [NUM_REQ-1:0] r, input int chg_steps, output txn_t t);
        t.gid = -1; t.gk = -1; t.en = 0; t.rk = -1; t.data_ok = 1; t.id = -1; t.sample = '0;
        req = r;
        for (int k = 0; k < 80 && t.rk < 0; k++) begin
            tick();
            if (obs_gnt != '0 && t.gk < 0) begin
                t.gk  = k;
                t.gid = onehot_idx(obs_gnt);
                req   = '0;
                if (chg_steps >= 0) steps = STEP_W'(chg_steps);
            end
            if (obs_en) begin
                t.en++;
                if (t.gid < 0 || obs_data !== slot(t.gid)) t.data_ok = 0;
            end
            if (obs_rv) begin
                t.rk = k; t.id = int'(obs_id); t.sample = obs_sample;
            end
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0]  r;
        logic [STEP_W-1:0]   st;
        logic [DATA_W-1:0]   data;
        logic [SAMPLE_W-1:0] sample;
        int                  exp_id;
        int                  exp_en;
    } vec_t;

    initial begin
        vec_t vecs [7];
        txn_t t;
        int   order [8];
        int   g [8];
        int   rt [8];
        int   ng, nr, cnt;

        reset = 1'b1; arb_en = 1'b1; steps = '0; req = '0; req_data = '0; lfsr_out16 = '0;
        tick(); tick();
        reset = 1'b0;

        // Pointer starts at NUM_REQ-1; each row's winner follows from the previous row's.
        vecs[0] = '{4'b0001, 5'd3,  12'h005, 16'hA5A5, 0, 3};
        vecs[1] = '{4'b1010, 5'd0,  12'h1F0, 16'h1234, 1, 1};
        vecs[2] = '{4'b1010, 5'd2,  12'h0C3, 16'hFFFF, 3, 2};
        vecs[3] = '{4'b0110, 5'd1,  12'h7E1, 16'h0001, 1, 1};
        vecs[4] = '{4'b0110, 5'd4,  12'h456, 16'h8000, 2, 4};
        vecs[5] = '{4'b1001, 5'd31, 12'hABC, 16'h5A5A, 3, 31};
        vecs[6] = '{4'b0100, 5'd5,  12'h321, 16'hC0DE, 2, 5};

        for (int v = 0; v < 7; v++) begin
            steps      = vecs[v].st;
            lfsr_out16 = vecs[v].sample;
            for (int i = 0; i < NUM_REQ; i++)
                req_data[i*DATA_W +: DATA_W] = vecs[v].data + DATA_W'(i * 12'h111);
            do_txn(vecs[v].r, -1, t);
            chk("vec_gnt_offset",   32'(t.gk),   32'd1);
            chk("vec_gnt_id",       32'(t.gid),  32'(vecs[v].exp_id));
            chk("vec_enable_count", 32'(t.en),   32'(vecs[v].exp_en));
            chk("vec_lfsr_data",    32'(t.data_ok), 32'd1);
            chk("vec_rsp_offset",   32'(t.rk),   32'(vecs[v].exp_en + 2));
            chk("vec_rsp_id",       32'(t.id),   32'(vecs[v].exp_id));
            chk("vec_rsp_sample",   32'(t.sample), 32'(vecs[v].sample));
            tick();
        end

        // All requesters active, steps=1: strict rotation, one response every 3 cycles.
        reset = 1'b1; tick(); reset = 1'b0;
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        steps = 5'd1; req = 4'b1111; ng = 0; nr = 0;
        for (int k = 0; k < 60 && nr < 8; k++) begin
            lfsr_out16 = SAMPLE_W'($urandom);
            tick();
            if (obs_gnt != '0 && ng < 8) begin
                g[ng] = onehot_idx(obs_gnt); ng++;
                if (ng == 8) req = '0;
            end
            if (obs_rv) begin rt[nr] = k; nr++; end
        end
        chk("rr_grant_count", 32'(ng), 32'd8);
        chk("rr_rsp_count",   32'(nr), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < ng) chk("rr_grant_order", 32'(g[i]), 32'(order[i]));
        for (int i = 1; i < 8; i++)
            if (i < nr) chk("rr_rsp_spacing", 32'(rt[i] - rt[i-1]), 32'd3);
        tick();

        // steps sampled only at grant: 2 -> 9 after gnt still gives 2 enable cycles.
        steps = 5'd2;
        do_txn(4'b0001, 9, t);
        chk("steps_change_enables", 32'(t.en), 32'd2);
        chk("steps_change_rsp",     32'(t.rk), 32'd4);
        steps = 5'd0;
        do_txn(4'b0010, -1, t);
        chk("steps0_enables", 32'(t.en), 32'd1);
        tick();

        // arb_en low blocks grants; raised -> requester 1 first; dropped mid-RUN -> completes, no more.
        reset = 1'b1; tick(); reset = 1'b0;
        req_data = 48'h444_333_222_111; lfsr_out16 = 16'hBEEF;
        arb_en = 1'b0; req = 4'b0110; steps = 5'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("arb_off_gnt",  32'(obs_gnt),  32'd0);
            chk("arb_off_busy", 32'(obs_busy), 32'd0);
        end
        arb_en = 1'b1; ng = -1;
        for (int k = 0; k < 10 && ng < 0; k++) begin
            tick();
            if (obs_gnt != '0) ng = onehot_idx(obs_gnt);
        end
        chk("arb_on_first_id", 32'(ng), 32'd1);
        arb_en = 1'b0; nr = 0; cnt = 0;
        for (int k = 0; k < 20 && nr == 0; k++) begin
            tick();
            if (obs_rv) begin nr = 1; chk("arb_drop_rsp_id", 32'(obs_id), 32'd1); end
        end
        chk("arb_drop_rsp_seen", 32'(nr), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (obs_gnt != '0) cnt++;
        end
        chk("arb_drop_no_grant", 32'(cnt), 32'd0);
        req = '0; arb_en = 1'b1;
        tick();

        // Reset in the 2nd RUN cycle of an 8-step transaction.
        steps = 5'd8; req = 4'b0001; ng = -1;
        for (int k = 0; k < 10 && ng < 0; k++) begin
            tick();
            if (obs_gnt != '0) ng = onehot_idx(obs_gnt);
        end
        chk("rst_mid_grant_id", 32'(ng), 32'd0);
        req = '0; reset = 1'b1;
        tick();
        chk("rst_mid_was_running", 32'(obs_en), 32'd1);
        reset = 1'b0;
        tick();
        chk("rst_after_gnt",    32'(obs_gnt),    32'd0);
        chk("rst_after_enable", 32'(obs_en),     32'd0);
        chk("rst_after_data",   32'(obs_data),   32'd0);
        chk("rst_after_valid",  32'(obs_rv),     32'd0);
        chk("rst_after_id",     32'(obs_id),     32'd0);
        chk("rst_after_sample", 32'(obs_sample), 32'd0);
        chk("rst_after_busy",   32'(obs_busy),   32'd0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs_rv) cnt++;
        end
        chk("rst_no_rsp", 32'(cnt), 32'd0);
        steps = 5'd2;
        do_txn(4'b0101, -1, t);
        chk("rst_ptr_id0", 32'(t.gid), 32'd0);
        do_txn(4'b0100, -1, t);
        chk("rst_next_id2", 32'(t.gid), 32'd2);
        tick();

        // Requester 2 holds req across its gnt: served again only after 3 and 0.
        reset = 1'b1; tick(); reset = 1'b0;
        steps = 5'd1; req = 4'b0100; ng = -1;
        for (int k = 0; k < 10 && ng < 0; k++) begin
            tick();
            if (obs_gnt != '0) ng = onehot_idx(obs_gnt);
        end
        chk("hold_first_id", 32'(ng), 32'd2);
        req = 4'b1101; order = '{3, 0, 2, 0, 0, 0, 0, 0}; ng = 0;
        for (int k = 0; k < 30 && ng < 3; k++) begin
            tick();
            if (obs_gnt != '0) begin g[ng] = onehot_idx(obs_gnt); ng++; end
        end
        chk("hold_grant_count", 32'(ng), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < ng) chk("hold_grant_order", 32'(g[i]), 32'(order[i]));
        req = '0;
        for (int k = 0; k < 5; k++) tick();

        // Random phase, checked entirely by the schedule model.
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 299) == 0);
            arb_en     = ($urandom_range(0, 9) != 0);
            req        = req ^ NUM_REQ'($urandom & $urandom);
            steps      = ($urandom_range(0, 9) == 0) ? STEP_W'($urandom_range(0, 31))
                                                     : STEP_W'($urandom_range(0, 4));
            req_data   = (NUM_REQ*DATA_W)'({$urandom, $urandom});
            lfsr_out16 = SAMPLE_W'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
